ds_lin_interp: RTL and testbench

//  Linear interpolator between the sine NCO and the delta-sigma modulator.
//  - Accepts low-rate unsigned (offset-binary) samples over a valid/ready handshake.
//  - Emits one sample per clock, ramping linearly from the previous sample to the new one

---
 rtl/ds_pkg.sv | 12 +
 rtl/ds_lin_interp.sv | 96 +++++++++
 tb/tb_ds_lin_interp.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ds_pkg.sv
// Shared constants and interpolator state encoding for the delta-sigma DAC path
// (used by the interpolator RTL and by the modulator bench).
package ds_pkg;
  localparam int DS_D_W = 16;
  localparam logic [DS_D_W-1:0] DS_MIDSCALE = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } interp_state_e;
endpackage

// File: rtl/ds_lin_interp.sv
// Linear interpolator feeding the delta-sigma modulator: one output sample per clock,
// ramping over 2^L_LOG2 clocks. Define LIN_INTERP_ROUND_EN for rounded (vs truncated) output.
module ds_lin_interp
  import ds_pkg::*;
#(
  parameter int D_W    = DS_D_W,
  parameter int L_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [D_W-1:0] in_data,
  output logic           in_ready,
  output logic [D_W-1:0] out_data,
  output logic           out_strobe,
  output logic           underrun
);
  localparam int AW = D_W + L_LOG2;
  localparam logic [D_W-1:0] MID = {1'b1, {(D_W-1){1'b0}}};

  interp_state_e          state_reg;
  logic [AW-1:0]          acc_reg;
  logic signed [D_W:0]    step_reg;
  logic [D_W-1:0]         target_reg;
  logic [L_LOG2-1:0]      phase_reg;
  logic                   underrun_reg;
  logic [D_W-1:0]         out_data_reg;
  logic                   out_strobe_reg;

  logic                   last_phase;
  logic                   accept;
  logic signed [D_W:0]    step_next;
  logic [AW-1:0]          step_ext;
  logic [AW-1:0]          acc_next;
  logic [D_W-1:0]         out_next;

  assign last_phase = &phase_reg;
  assign in_ready   = !rst && (state_reg == IDLE || state_reg == HOLD ||
                               (state_reg == RAMP && last_phase));
  assign accept     = in_valid && in_ready;
  assign step_next  = $signed({1'b0, in_data}) - $signed({1'b0, target_reg});
  // step_reg is signed, so widening sign-extends; the unsigned add then wraps correctly.
  assign step_ext   = AW'(step_reg);

  always_comb begin
    acc_next = acc_reg;
    if (accept) begin
      acc_next = {target_reg, {L_LOG2{1'b0}}};
    end else if (state_reg == RAMP) begin
      acc_next = acc_reg + step_ext;
    end
  end

`ifdef LIN_INTERP_ROUND_EN
  localparam logic [AW:0] ROUND_HALF = (AW + 1)'(1) << (L_LOG2 - 1);
  logic [D_W:0] rounded_hi;
  assign rounded_hi = (D_W + 1)'(({1'b0, acc_next} + ROUND_HALF) >> L_LOG2);
  assign out_next   = rounded_hi[D_W] ? {D_W{1'b1}} : rounded_hi[D_W-1:0];
`else
  assign out_next = acc_next[AW-1:L_LOG2];
`endif

  // Output is registered from acc_next so it reflects the accumulator after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      acc_reg        <= {MID, {L_LOG2{1'b0}}};
      step_reg       <= '0;
      target_reg     <= MID;
      phase_reg      <= '0;
      underrun_reg   <= 1'b0;
      out_data_reg   <= MID;
      out_strobe_reg <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      out_data_reg   <= out_next;
      out_strobe_reg <= accept;
      if (accept) begin
        step_reg   <= step_next;
        target_reg <= in_data;
        phase_reg  <= '0;
        state_reg  <= RAMP;
      end else if (state_reg == RAMP) begin
        phase_reg <= phase_reg + L_LOG2'(1);
        if (last_phase) begin
          state_reg    <= HOLD;
          underrun_reg <= 1'b1;
        end
      end
    end
  end

  assign out_data   = out_data_reg;
  assign out_strobe = out_strobe_reg;
  assign underrun   = underrun_reg;
endmodule

// File: tb/tb_ds_lin_interp.sv
// Self-checking bench for ds_lin_interp (D_W=16, L_LOG2=4) against a segment-level
// arithmetic model: out = prev + floor(k*(new-prev)/16) k edges after an accept.
module tb_ds_lin_interp;
  localparam int D_W = 16;
  localparam int SEG = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [D_W-1:0] in_data = '0;
  logic           in_ready;
  logic [D_W-1:0] out_data;
  logic           out_strobe;
  logic           underrun;

  int total = 0;
  int bad = 0;

  // Reference model: endpoints of the current segment and edges elapsed since its accept.
  int m_prev = 32'h8000;
  int m_new  = 32'h8000;
  int m_k    = SEG;
  bit m_underrun = 1'b0;
  bit m_strobe = 1'b0;

  ds_lin_interp #(.D_W(D_W), .L_LOG2(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_data(out_data), .out_strobe(out_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_out(int prev, int nw, int k);
    int num;
    num = SEG * prev + k * (nw - prev);
`ifdef LIN_INTERP_ROUND_EN
    num = num + SEG / 2;
`endif
    num = num / SEG;
    if (num > 65535) num = 65535;
    return num[15:0];
  endfunction

  function automatic bit m_ready();
    return !rst && (m_k >= SEG - 1);
  endfunction

  function automatic logic [15:0] m_out();
    return exp_out(m_prev, m_new, (m_k > SEG) ? SEG : m_k);
  endfunction

  // Advance one clock edge, update the model, and leave time 1 unit past the edge.
  task automatic tick();
    bit acc;
    acc = in_valid && m_ready();
    @(posedge clk);
    if (rst) begin
      m_prev = 32'h8000; m_new = 32'h8000; m_k = SEG; m_underrun = 1'b0; m_strobe = 1'b0;
    end else if (acc) begin
      m_prev = m_new; m_new = int'(in_data); m_k = 0; m_strobe = 1'b1;
    end else begin
      m_strobe = 1'b0;
      if (m_k == SEG - 1) m_underrun = 1'b1;
      if (m_k < SEG) m_k++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL reset_out: got %h want 8000", out_data); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    total++; if (out_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", out_strobe); end
    $display("reset: out=%h ready=%b underrun=%b", out_data, in_ready, underrun);
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 16'h8010;
    tick();
    in_valid = 1'b0;
    total++; if (out_strobe !== 1'b1) begin bad++; $display("FAIL single_strobe: got %b want 1", out_strobe); end
    for (int k = 1; k <= SEG; k++) begin
      tick();
      total++;
      if (out_data !== m_out() || out_data !== 16'(16'h8000 + k)) begin
        bad++; $display("FAIL single_ramp k=%0d: got %h want %h", k, out_data, m_out());
      end
      total++; if (out_strobe !== 1'b0) begin bad++; $display("FAIL single_strobe_low k=%0d: got %b want 0", k, out_strobe); end
    end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL single_underrun: got %b want 1", underrun); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_hold_ready: got %b want 1", in_ready); end
    $display("single 8010: out=%h underrun=%b", out_data, underrun);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 16'($urandom_range(0, 65535));
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL rstmid_out: got %h want 8000", out_data); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rstmid_underrun: got %b want 0", underrun); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL rstmid_discard: got %h want 8000", out_data); end
    end
    $display("reset mid-ramp: out=%h underrun=%b", out_data, underrun);
  endtask

  task automatic test_stream();
    logic [15:0] q[$];
    int idx, cycles, ready_cnt;
    logic [15:0] last_out;
    bit acc;
    q = {16'hFFFF, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 5; i++) q.push_back(16'($urandom_range(0, 65535)));
    idx = 0; cycles = 0; ready_cnt = 0;
    in_valid = 1'b1; in_data = q[0];
    last_out = out_data;
    while (idx < q.size() && cycles < 200) begin
      total++;
      if (in_ready !== m_ready()) begin bad++; $display("FAIL stream_ready cyc=%0d: got %b want %b", cycles, in_ready, m_ready()); end
      if (in_ready === 1'b1) ready_cnt++;
      acc = in_valid && m_ready();
      tick();
      cycles++;
      if (acc) begin
        idx++;
        if (idx < q.size()) in_data = q[idx];
        else in_valid = 1'b0;
      end
      total++;
      if (out_data !== m_out()) begin bad++; $display("FAIL stream_out cyc=%0d: got %h want %h", cycles, out_data, m_out()); end
      if (m_k >= 1) begin
        total++;
        if ((m_new >= m_prev) ? (out_data < last_out) : (out_data > last_out)) begin
          bad++; $display("FAIL stream_monotonic cyc=%0d: got %h after %h", cycles, out_data, last_out);
        end
      end
      last_out = out_data;
    end
    in_valid = 1'b0;
    total++; if (idx < q.size()) begin bad++; $display("FAIL stream_timeout: accepted %0d want %0d", idx, q.size()); end
    total++; if (ready_cnt !== q.size()) begin bad++; $display("FAIL stream_ready_count: got %0d want %0d", ready_cnt, q.size()); end
    total++; if (cycles !== 1 + SEG * (q.size() - 1)) begin bad++; $display("FAIL stream_cycles: got %0d want %0d", cycles, 1 + SEG * (q.size() - 1)); end
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL stream_underrun: got %b want 0", underrun); end
    $display("stream: %0d samples in %0d cycles, underrun=%b", idx, cycles, underrun);
  endtask

  task automatic test_stall();
    int held;
    held = m_new;
    for (int c = 0; c < 40; c++) begin
      tick();
      total++; if (out_data !== m_out()) begin bad++; $display("FAIL stall_out c=%0d: got %h want %h", c, out_data, m_out()); end
    end
    total++; if (out_data !== 16'(held)) begin bad++; $display("FAIL stall_frozen: got %h want %h", out_data, 16'(held)); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL stall_underrun: got %b want 1", underrun); end
    in_valid = 1'b1; in_data = 16'h9000;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= SEG; k++) begin
      tick();
      total++; if (out_data !== m_out()) begin bad++; $display("FAIL stall_ramp k=%0d: got %h want %h", k, out_data, m_out()); end
    end
    total++; if (out_data !== 16'h9000) begin bad++; $display("FAIL stall_end: got %h want 9000", out_data); end
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL stall_sticky: got %b want 1", underrun); end
    $display("stall then 9000: out=%h underrun=%b", out_data, underrun);
  endtask

  task automatic test_lsb_ramp();
    int first, want;
    in_valid = 1'b1; in_data = 16'h8000;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < SEG + 2; k++) tick();
    total++; if (out_data !== 16'h8000) begin bad++; $display("FAIL lsb_start: got %h want 8000", out_data); end
    in_valid = 1'b1; in_data = 16'h8001;
    tick();
    in_valid = 1'b0;
    first = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (first < 0 && out_data === 16'h8001) first = k;
    end
`ifdef LIN_INTERP_ROUND_EN
    want = 8;
`else
    want = 16;
`endif
    total++; if (first !== want) begin bad++; $display("FAIL lsb_first_reach: got k=%0d want k=%0d", first, want); end
    $display("lsb ramp 8000->8001: first reached at k=%0d", first);
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_stream();
    test_stall();
    test_lsb_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
